// File: rtl/wb_write_arbiter.sv
// Writeback arbiter for the register file's single write port: merges the in-order
// ALU stream with buffered load returns and flags reads of registers with writes pending.
module wb_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int ZERO_DISCARD = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          ld_valid,
    input  logic [ADDR_W-1:0]             ld_rd,
    input  logic [DATA_W-1:0]             ld_data,
    output logic                          ld_ready,
    output logic                          stall_alu,
    input  logic [ADDR_W-1:0]             RA,
    input  logic [ADDR_W-1:0]             RB,
    output logic                          hazard_a,
    output logic                          hazard_b,
    output logic [ADDR_W-1:0]             RW,
    output logic [DATA_W-1:0]             Bus_W,
    output logic                          reg_write,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              stall_q, stall_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] bus_q, bus_d;

    logic              push, pop, alu_acc, fifo_empty, sel_any, discard;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic [FIFO_DEPTH-1:0] ent_vld;

    // Ready comes from the registered count only, so a same-cycle pop never frees a full FIFO.
    assign ld_ready   = rst_n & (count_q < CNT_W'(FIFO_DEPTH));
    assign stall_alu  = stall_q;
    assign reg_write  = wr_q;
    assign RW         = rw_q;
    assign Bus_W      = bus_q;
    assign fifo_count = count_q;

    always_comb begin
        push       = ld_valid & ld_ready;
        fifo_empty = (count_q == '0);
        alu_acc    = alu_valid & ~stall_q;
        pop        = ~fifo_empty & (stall_q | ~alu_valid);
        sel_any    = pop | alu_acc;
        sel_rd     = pop ? fifo_rd_q[rd_ptr_q]   : alu_rd;
        sel_data   = pop ? fifo_data_q[rd_ptr_q] : alu_data;
        discard    = (ZERO_DISCARD != 0) && (sel_rd == '0);

        wr_d  = sel_any & ~discard;
        rw_d  = wr_d ? sel_rd   : rw_q;
        bus_d = wr_d ? sel_data : bus_q;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        if (fifo_empty || pop)
            starve_d = '0;
        else if (starve_q == SW'(STARVE_LIMIT))
            starve_d = starve_q;
        else
            starve_d = starve_q + SW'(1);
        stall_d = (starve_d == SW'(STARVE_LIMIT));
    end

    always_comb begin
        ent_vld  = '0;
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            logic [PTR_W-1:0] off;
            off        = PTR_W'(i) - rd_ptr_q;
            ent_vld[i] = ({1'b0, off} < count_q);
            if (ent_vld[i] && fifo_rd_q[i] == RA) hazard_a = 1'b1;
            if (ent_vld[i] && fifo_rd_q[i] == RB) hazard_b = 1'b1;
        end
        if (wr_q && rw_q == RA) hazard_a = 1'b1;
        if (wr_q && rw_q == RB) hazard_b = 1'b1;
        if (ZERO_DISCARD != 0 && RA == '0) hazard_a = 1'b0;
        if (ZERO_DISCARD != 0 && RB == '0) hazard_b = 1'b0;
    end

    // Payload storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= ld_rd;
            fifo_data_q[wr_ptr_q] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            wr_q     <= 1'b0;
            rw_q     <= '0;
            bus_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            wr_q     <= wr_d;
            rw_q     <= rw_d;
            bus_q    <= bus_d;
        end
    end

endmodule
